// File: rtl/dmux8way16_buf_pkg.sv
// Shared constants, lane state type and select decoder for the dmux8way16_buf slice.
package dmux8way16_buf_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] LANE_A = 3'd0;
  localparam logic [SEL_W-1:0] LANE_B = 3'd1;
  localparam logic [SEL_W-1:0] LANE_C = 3'd2;
  localparam logic [SEL_W-1:0] LANE_D = 3'd3;
  localparam logic [SEL_W-1:0] LANE_E = 3'd4;
  localparam logic [SEL_W-1:0] LANE_F = 3'd5;
  localparam logic [SEL_W-1:0] LANE_G = 3'd6;
  localparam logic [SEL_W-1:0] LANE_H = 3'd7;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  function automatic logic [LANES-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [LANES-1:0] v;
    case (s)
      LANE_A:  v = 8'b0000_0001;
      LANE_B:  v = 8'b0000_0010;
      LANE_C:  v = 8'b0000_0100;
      LANE_D:  v = 8'b0000_1000;
      LANE_E:  v = 8'b0001_0000;
      LANE_F:  v = 8'b0010_0000;
      LANE_G:  v = 8'b0100_0000;
      LANE_H:  v = 8'b1000_0000;
      default: v = 8'b0000_0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dmux8way16_buf_lane.sv
// One output lane: a holding register plus its EMPTY/FULL state.
// A load always wins over a take, so a lane drained and refilled in one cycle stays FULL.
module dmux_lane
  import dmux8way16_buf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             take,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             can_load
);

  lane_state_e      r_state;
  lane_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_data;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LANE_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LANE_EMPTY: begin
        if (load) w_state_nxt = LANE_FULL;
        else      w_state_nxt = LANE_EMPTY;
      end
      LANE_FULL: begin
        if (load)      w_state_nxt = LANE_FULL;
        else if (take) w_state_nxt = LANE_EMPTY;
        else           w_state_nxt = LANE_FULL;
      end
      default: w_state_nxt = LANE_EMPTY;
    endcase
  end

  // data register: changes only on load, otherwise keeps the (possibly stale) word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {WIDTH{1'b0}};
    end else if (load) begin
      r_data <= din;
    end
  end

  // output decode
  always_comb begin
    valid    = (r_state == LANE_FULL);
    can_load = (r_state != LANE_FULL) | take;
    dout     = r_data;
  end

endmodule

// File: rtl/dmux8way16_buf.sv
// Registered 8-way demultiplexer: steers each accepted word into lane[sel] and holds it
// there until that lane's consumer takes it; each lane has its own valid/ready pair.
module dmux8way16_buf
  import dmux8way16_buf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready
);

  logic [LANES-1:0] w_valid;
  logic [LANES-1:0] w_can_load;
  logic [LANES-1:0] w_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_data [LANES];

  // handshake and one-hot load steering; rst_n gates in_ready so nothing lands under reset
  always_comb begin
    in_ready = rst_n & w_can_load[sel];
    w_accept = in_valid & in_ready;
    if (w_accept) begin
      w_load = sel_onehot(sel);
    end else begin
      w_load = {LANES{1'b0}};
    end
  end

  for (genvar g_i = 0; g_i < LANES; g_i++) begin : g_lane
    dmux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load[g_i]),
      .din      (in),
      .take     (out_ready[g_i]),
      .dout     (w_data[g_i]),
      .valid    (w_valid[g_i]),
      .can_load (w_can_load[g_i])
    );
  end

  assign out_valid = w_valid;
  assign a = w_data[LANE_A];
  assign b = w_data[LANE_B];
  assign c = w_data[LANE_C];
  assign d = w_data[LANE_D];
  assign e = w_data[LANE_E];
  assign f = w_data[LANE_F];
  assign g = w_data[LANE_G];
  assign h = w_data[LANE_H];

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Randomized and directed bench for dmux8way16_buf, checked every cycle against an
// array-based model of eight independent holding slots.
module tb_dmux8way16_buf;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [2:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  logic [15:0] m_data  [8];
  logic        m_valid [8];

  dmux8way16_buf #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_out(input int k);
    case (k)
      0: return a;
      1: return b;
      2: return c;
      3: return d;
      4: return e;
      5: return f;
      6: return g;
      7: return h;
      default: return 16'hxxxx;
    endcase
  endfunction

  // model: a word goes into slot[sel] when accepted; a slot empties when taken unless refilled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        m_data[k]  <= 16'h0000;
        m_valid[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (m_valid[k] && out_ready[k]) m_valid[k] <= 1'b0;
      end
      if (in_valid && (!m_valid[sel] || out_ready[sel])) begin
        m_data[sel]  <= in;
        m_valid[sel] <= 1'b1;
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] exp_v;
      for (int k = 0; k < 8; k++) begin
        exp_v[k] = m_valid[k];
        check($sformatf("lane%0d_data", k), {16'h0000, lane_out(k)}, {16'h0000, m_data[k]});
      end
      check("out_valid", {24'h0, out_valid}, {24'h0, exp_v});
      check("in_ready", {31'h0, in_ready},
            {31'h0, rst_n & (~m_valid[sel] | out_ready[sel])});
    end
  end

  task automatic drive(input logic iv, input logic [2:0] s, input logic [15:0] dat,
                       input logic [7:0] ordy);
    in_valid  = iv;
    sel       = s;
    in        = dat;
    out_ready = ordy;
  endtask

  // advance one clock; returns at negedge + 1
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [15:0] fill_vals [8];

  initial begin
    fill_vals[0] = 16'hAAAA; fill_vals[1] = 16'h5555; fill_vals[2] = 16'hFFFF;
    fill_vals[3] = 16'h0000; fill_vals[4] = 16'h1234; fill_vals[5] = 16'h4321;
    fill_vals[6] = 16'h9876; fill_vals[7] = 16'h6789;

    rst_n = 1'b0;
    drive(1'b1, 3'd0, 16'hAAAA, 8'h00);
    tick();
    tick();
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_out_valid", {24'h0, out_valid}, 32'h0);
    check("rst_a_or_h", {16'h0, a | b | c | d | e | f | g | h}, 32'h0);

    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", {31'h0, in_ready}, 32'h1);
    chk_en = 1'b1;
    tick();

    // fill all lanes, one per cycle, no consumer
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k[2:0], fill_vals[k], 8'h00);
      #1;
      check("fill_ready", {31'h0, in_ready}, 32'h1);
      tick();
      check("fill_lane", {16'h0, lane_out(k)}, {16'h0, fill_vals[k]});
    end
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    check("fill_out_valid", {24'h0, out_valid}, 32'hFF);
    check("fill_h", {16'h0, h}, 32'h6789);

    // backpressure on lane c
    drive(1'b1, 3'd2, 16'hBEEF, 8'h00);
    #1;
    check("bp_stall_ready", {31'h0, in_ready}, 32'h0);
    tick();
    check("bp_c_held", {16'h0, c}, 32'hFFFF);
    drive(1'b1, 3'd2, 16'hBEEF, 8'h04);
    #1;
    check("bp_drain_ready", {31'h0, in_ready}, 32'h1);
    tick();
    check("bp_c_new", {16'h0, c}, 32'hBEEF);
    check("bp_c_valid", {31'h0, out_valid[2]}, 32'h1);

    // empty b,d,e,f,g, then drain a and h while loading f with c stalled
    drive(1'b0, 3'd0, 16'h0000, 8'b0111_1010);
    tick();
    check("drain_out_valid", {24'h0, out_valid}, {24'h0, 8'b1000_0101});
    drive(1'b1, 3'd5, 16'h0F0F, 8'b1000_0001);
    #1;
    check("indep_ready", {31'h0, in_ready}, 32'h1);
    tick();
    check("indep_f", {16'h0, f}, 32'h0F0F);
    check("indep_out_valid", {24'h0, out_valid}, {24'h0, 8'b0010_0100});
    check("stale_a", {16'h0, a}, 32'hAAAA);

    // idle input sweep
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, k[2:0], 16'hDEAD, 8'h00);
      tick();
    end
    check("idle_out_valid", {24'h0, out_valid}, {24'h0, 8'b0010_0100});
    check("idle_b_stale", {16'h0, b}, 32'h5555);

    // refill remaining empty lanes, then asynchronous mid-cycle reset
    for (int k = 0; k < 8; k++) begin
      if (k != 2 && k != 5) begin
        drive(1'b1, k[2:0], 16'h1111 * k[15:0], 8'h00);
        tick();
      end
    end
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    check("pre_rst_out_valid", {24'h0, out_valid}, 32'hFF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {24'h0, out_valid}, 32'h0);
    check("async_lanes", {16'h0, a | b | c | d | e | f | g | h}, 32'h0);
    check("async_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 3'd4, 16'h1234, 8'h00);
    tick();
    check("post_rst_e", {16'h0, e}, 32'h1234);
    check("post_rst_valid", {24'h0, out_valid}, 32'h10);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
            16'($urandom), 8'($urandom & $urandom));
      tick();
    end
    drive(1'b0, 3'd0, 16'h0000, 8'hFF);
    tick();
    check("final_drain", {24'h0, out_valid}, 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
